fp_add_align: RTL and testbench

//  Operand swap/alignment stage of the single-precision FP adder; sits directly downstream of the
//  32-bit less-than comparator. Orders two IEEE-754 singles by magnitude (a 31-bit unsigned less-than
//  on {exp,frac}), then right-shifts the smaller significand one bit per cycle, with guard/round/sticky.

---
 rtl/fp_add_align.sv | 112 +++++++++++
 tb/tb_fp_add_align.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_align.sv
// Swap/alignment stage of the single-precision adder: orders two singles by magnitude and
// right-shifts the smaller significand one bit per cycle, folding shifted-out bits into sticky.
module fp_add_align #(
  parameter int MAX_SHIFT = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        big_sign,
  output logic [7:0]  big_exp,
  output logic [26:0] big_man,
  output logic        small_sign,
  output logic [26:0] small_man,
  output logic [7:0]  exp_diff,
  output logic        swapped,
  output logic        special,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid is never withdrawn and its payload never changes until that transfer.
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          swap_in, special_in;
  logic [31:0]   big_in, small_in;
  logic [7:0]    big_eff, small_eff, diff_in;
  logic [CW-1:0] cnt_in;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign dbg_state = state;

  // Ordering on {exp,frac} as an unsigned integer gives the magnitude order of IEEE singles.
  always_comb begin
    swap_in    = (op_a[30:0] < op_b[30:0]);
    big_in     = swap_in ? op_b : op_a;
    small_in   = swap_in ? op_a : op_b;
    special_in = (op_a[30:23] == 8'hFF) || (op_b[30:23] == 8'hFF);
    big_eff    = (big_in[30:23] == 8'd0) ? 8'd1 : big_in[30:23];
    small_eff  = (small_in[30:23] == 8'd0) ? 8'd1 : small_in[30:23];
    diff_in    = big_eff - small_eff;
    cnt_in     = (diff_in > 8'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : diff_in[CW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (special_in || (cnt_in == '0)) state_nxt = DONE;
          else                              state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      big_sign   <= 1'b0;
      big_exp    <= 8'd0;
      big_man    <= 27'd0;
      small_sign <= 1'b0;
      small_man  <= 27'd0;
      exp_diff   <= 8'd0;
      swapped    <= 1'b0;
      special    <= 1'b0;
    end else if (accept) begin
      cnt        <= special_in ? '0 : cnt_in;
      big_sign   <= big_in[31];
      big_exp    <= big_eff;
      big_man    <= {(big_in[30:23] != 8'd0), big_in[22:0], 3'b000};
      small_sign <= small_in[31];
      small_man  <= {(small_in[30:23] != 8'd0), small_in[22:0], 3'b000};
      exp_diff   <= diff_in;
      swapped    <= swap_in;
      special    <= special_in;
    end else if (state == SHIFT) begin
      // Bit 0 is sticky: it absorbs every bit that falls off the bottom.
      small_man <= {1'b0, small_man[26:2], small_man[1] | small_man[0]};
      cnt       <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_fp_add_align.sv
// Self-checking bench for fp_add_align: directed cases, output hold, mid-operation reset
// and randomized back-to-back operations against an expected-result queue.
module tb_fp_add_align;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic        big_sign;
  logic [7:0]  big_exp;
  logic [26:0] big_man;
  logic        small_sign;
  logic [26:0] small_man;
  logic [7:0]  exp_diff;
  logic        swapped;
  logic        special;
  logic [1:0]  dbg_state;

  typedef struct packed {
    logic        bs;
    logic [7:0]  be;
    logic [26:0] bm;
    logic        ss;
    logic [26:0] sm;
    logic [7:0]  ed;
    logic        sw;
    logic        sp;
    logic [5:0]  lat;
  } exp_t;

  localparam int EW = $bits(exp_t);
  localparam int RW = EW - 6;

  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  fp_add_align #(.MAX_SHIFT(27)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .big_sign(big_sign), .big_exp(big_exp), .big_man(big_man),
    .small_sign(small_sign), .small_man(small_man), .exp_diff(exp_diff),
    .swapped(swapped), .special(special), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] observed();
    return {big_sign, big_exp, big_man, small_sign, small_man, exp_diff, swapped, special};
  endfunction

  // Reference model: sticky bit computed as an OR-reduction over the shifted-out window.
  function automatic logic [EW-1:0] model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] bg, sl, mask;
    logic [7:0]  be, se;
    logic [26:0] man;
    int          n;
    e.sw = (a[30:0] < b[30:0]);
    bg   = e.sw ? b : a;
    sl   = e.sw ? a : b;
    e.sp = (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    be   = (bg[30:23] == 8'd0) ? 8'd1 : bg[30:23];
    se   = (sl[30:23] == 8'd0) ? 8'd1 : sl[30:23];
    e.bs = bg[31];
    e.ss = sl[31];
    e.be = be;
    e.ed = be - se;
    e.bm = {(bg[30:23] != 8'd0), bg[22:0], 3'b000};
    man  = {(sl[30:23] != 8'd0), sl[22:0], 3'b000};
    n    = e.sp ? 0 : ((e.ed > 8'd27) ? 27 : int'(e.ed));
    if (n > 0) begin
      mask     = (32'd2 << n) - 32'd1;
      e.sm     = man >> n;
      e.sm[0]  = |({5'd0, man} & mask);
    end else begin
      e.sm = man;
    end
    e.lat = 6'(n + 1);
    return e;
  endfunction

  // Driver tasks
  task automatic drive_op(input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL drive_in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  // Waits for out_valid (bounded), then holds out_ready low for 'hold' cycles.
  // Leaves the result presented without completing the handshake.
  task automatic collect_result(input int hold, output exp_t e);
    int lat;
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: output with no expected entry");
      e = '0;
      return;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (!out_valid) begin
      n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1 within 64 cycles", out_valid);
      return;
    end
    if (lat !== int'(e.lat)) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, e.lat);
    end
    n_checks++;
    if (observed() !== e[EW-1:6]) begin
      n_fail++;
      $display("FAIL result: got %h required %h", observed(), e[EW-1:6]);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, e[EW-1:6]}) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: got v=%b r=%b %h required v=1 r=0 %h",
                 i, out_valid, in_ready, observed(), e[EW-1:6]);
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_handshake: got v=%b r=%b required v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({out_valid, in_ready, dbg_state, observed()} !== {1'b0, 1'b1, 2'd0, {RW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%b st=%0d %h required v=0 r=1 st=0 all zero",
               out_valid, in_ready, dbg_state, observed());
    end
  endtask

  task automatic test_equal_mag();
    exp_t e;
    drive_op(32'h3F800000, 32'h3F800000);
    collect_result(0, e);
    n_checks++;
    if ({swapped, exp_diff, big_man, small_man} !== {1'b0, 8'd0, 27'h4000000, 27'h4000000}) begin
      n_fail++;
      $display("FAIL equal_mag: got sw=%b ed=%h bm=%h sm=%h required 0 00 4000000 4000000",
               swapped, exp_diff, big_man, small_man);
    end
    handshake();
  endtask

  task automatic test_swap();
    exp_t e;
    drive_op(32'h3F800000, 32'h40800000);
    collect_result(0, e);
    n_checks++;
    if ({swapped, big_exp, exp_diff, small_man} !== {1'b1, 8'h81, 8'd2, 27'h1000000}) begin
      n_fail++;
      $display("FAIL swap: got sw=%b be=%h ed=%h sm=%h required 1 81 02 1000000",
               swapped, big_exp, exp_diff, small_man);
    end
    handshake();
  endtask

  task automatic test_guard();
    exp_t e;
    drive_op(32'h3F800001, 32'h33800000);
    collect_result(0, e);
    n_checks++;
    if ({exp_diff, small_man, big_man} !== {8'd24, 27'h0000004, 27'h4000008}) begin
      n_fail++;
      $display("FAIL guard: got ed=%0d sm=%h bm=%h required 24 0000004 4000008",
               exp_diff, small_man, big_man);
    end
    handshake();
  endtask

  task automatic test_saturate();
    exp_t e;
    drive_op(32'h3F800000, 32'h2B800000);
    collect_result(0, e);
    n_checks++;
    if ({exp_diff, small_man} !== {8'd40, 27'h0000001}) begin
      n_fail++;
      $display("FAIL saturate: got ed=%0d sm=%h required 40 0000001", exp_diff, small_man);
    end
    handshake();
  endtask

  task automatic test_hold_and_special();
    exp_t e;
    drive_op(32'h3F800000, 32'h40800000);
    // Offer a different operation while busy; it must be ignored.
    in_valid = 1'b1;
    op_a = 32'h12345678;
    op_b = 32'h42000000;
    collect_result(5, e);
    in_valid = 1'b0;
    handshake();
    drive_op(32'h7FC00000, 32'h40800000);
    collect_result(0, e);
    n_checks++;
    if ({special, swapped, big_exp, big_man, small_man} !==
        {1'b1, 1'b0, 8'hFF, 27'h6000000, 27'h4000000}) begin
      n_fail++;
      $display("FAIL special: got sp=%b sw=%b be=%h bm=%h sm=%h required 1 0 ff 6000000 4000000",
               special, swapped, big_exp, big_man, small_man);
    end
    handshake();
  endtask

  task automatic test_reset_mid_op();
    exp_t e;
    drive_op(32'h3F800000, 32'h2B800000);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    void'(exp_q.pop_front());
    n_checks++;
    if ({out_valid, dbg_state, observed()} !== {1'b0, 2'd0, {RW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_mid_op: got v=%b st=%0d %h required v=0 st=0 all zero",
               out_valid, dbg_state, observed());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release: got r=%b v=%b required r=1 v=0", in_ready, out_valid);
    end
    test_equal_mag();
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [7:0]  ea, eb;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      ea = 8'($urandom_range(0, 254));
      eb = 8'($urandom_range(0, 40));
      eb = (ea > eb) ? ea - eb : 8'd0;
      if (i % 8 == 3) ea = 8'hFF;
      if (i % 8 == 5) begin ea = 8'd0; eb = 8'd1; end
      a = {1'($urandom_range(0, 1)), ea, 23'($urandom)};
      b = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
      if (i % 2 == 1) drive_op(b, a);
      else            drive_op(a, b);
      collect_result($urandom_range(0, 2), e);
      handshake();
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    #12;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    test_equal_mag();
    test_swap();
    test_guard();
    test_saturate();
    test_hold_and_special();
    test_reset_mid_op();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
